dram_mux_model: RTL and testbench

Clock-sampled, parametrised successor to the single-bit multiplexed-address DRAM model. Covers 4116/4164/4416-class parts: row/column address multiplexing, DW-bit data and 2^(2*AW) words.
Adds read-modify-write, page mode, RAS-only refresh and CAS-before-RAS (CBR) refresh. Also flags protocol violations.
Used in ULA/system benches as the RAM behind the video/CPU arbiter. Strobes are oversampled on CLK, so the model runs synchronously.

---
 rtl/dram_mux_model_pkg.sv | 21 ++
 rtl/dram_strobe_edge.sv | 25 ++
 rtl/dram_mux_model.sv | 175 +++++++++++++++++
 tb/tb_dram_mux_model.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_mux_model_pkg.sv
// rtl/dram_mux_model_pkg.sv - shared state encoding and sizing helpers for dram_mux_model
package dram_mux_model_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW_OPEN,
        ST_COL_ACTIVE,
        ST_CBR_PEND,
        ST_CBR_REFRESH
    } dram_state_t;

    function automatic int dram_words(input int aw);
        return 1 << (2 * aw);
    endfunction

    // The word address is {row, col}, so it is twice the multiplexed width.
    function automatic int dram_addr_bits(input int aw);
        return 2 * aw;
    endfunction

endpackage

// File: rtl/dram_strobe_edge.sv
// rtl/dram_strobe_edge.sv - registered fall/rise detector for one active-low strobe
module dram_strobe_edge (
    input  logic clk,
    input  logic resetn,
    input  logic sig,
    output logic fall,
    output logic rise
);

    logic prev;

    // Previous sample resets low so a strobe held low across reset release
    // produces no fall until it has risen and fallen again.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign fall = prev & ~sig;
    assign rise = ~prev & sig;

endmodule

// File: rtl/dram_mux_model.sv
// rtl/dram_mux_model.sv - clock-sampled multiplexed DRAM model; DRAM_MUX_MODEL_REFRESH_CHECK_EN adds row decay checking
module dram_mux_model
    import dram_mux_model_pkg::*;
#(
    parameter int AW         = 7,
    parameter int DW         = 1,
    parameter int RFSH_LIMIT = 2048
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] Din,
    input  logic          nWRITE,
    input  logic          nRAS,
    input  logic          nCAS,
    output logic [DW-1:0] Dout,
    output logic          Dout_oe,
    output logic [AW-1:0] rfsh_row,
    output logic          proto_err,
    output logic          refresh_err
);

    localparam int ADDR_W = dram_addr_bits(AW);
    localparam int WORDS  = dram_words(AW);
    localparam int ROWS   = 1 << AW;

    logic ras_fall, ras_rise, cas_fall, cas_rise, we_fall, we_rise_unused;

    dram_strobe_edge u_ras_edge (.clk(CLK), .resetn(nRESET), .sig(nRAS),   .fall(ras_fall), .rise(ras_rise));
    dram_strobe_edge u_cas_edge (.clk(CLK), .resetn(nRESET), .sig(nCAS),   .fall(cas_fall), .rise(cas_rise));
    dram_strobe_edge u_we_edge  (.clk(CLK), .resetn(nRESET), .sig(nWRITE), .fall(we_fall),  .rise(we_rise_unused));

    dram_state_t   state;
    logic [AW-1:0] row_q;
    logic [AW-1:0] col_q;
    logic          rd_pend;
    logic          wr_done;
    logic          row_decayed;

    logic [DW-1:0]     mem [WORDS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;

    // Early write addresses the column on A; a read-modify-write reuses the latched column.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = {row_q, col_q};
        if (state == ST_ROW_OPEN && cas_fall && !ras_rise && !nWRITE) begin
            mem_we = 1'b1;
            mem_wa = {row_q, A};
        end else if (state == ST_COL_ACTIVE && we_fall && !nCAS && !wr_done) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wa] <= Din;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            rd_pend   <= 1'b0;
            wr_done   <= 1'b0;
            Dout      <= '0;
            Dout_oe   <= 1'b0;
            rfsh_row  <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            rd_pend   <= 1'b0;
            if (rd_pend) begin
                Dout    <= row_decayed ? '0 : mem[{row_q, col_q}];
                Dout_oe <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (ras_fall) begin
                        row_q     <= A;
                        proto_err <= cas_fall;
                        state     <= ST_ROW_OPEN;
                    end else if (cas_fall && nRAS) begin
                        state <= ST_CBR_PEND;
                    end
                end
                ST_CBR_PEND: begin
                    if (ras_fall) begin
                        rfsh_row <= rfsh_row + 1'b1;
                        state    <= ST_CBR_REFRESH;
                    end else if (cas_rise) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CBR_REFRESH: begin
                    if (ras_rise) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ROW_OPEN: begin
                    if (ras_rise) begin
                        state <= ST_IDLE;
                    end else if (cas_fall) begin
                        col_q   <= A;
                        wr_done <= !nWRITE;
                        rd_pend <= nWRITE;
                        state   <= ST_COL_ACTIVE;
                    end
                end
                ST_COL_ACTIVE: begin
                    if (mem_we) begin
                        wr_done <= 1'b1;
                    end
                    // An access whose RAS already ended finishes here back in IDLE.
                    if (cas_rise) begin
                        Dout_oe <= 1'b0;
                        state   <= nRAS ? ST_IDLE : ST_ROW_OPEN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DRAM_MUX_MODEL_REFRESH_CHECK_EN
    localparam int             AGE_W   = $clog2(RFSH_LIMIT + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RFSH_LIMIT + 1);

    logic [AGE_W-1:0] age [ROWS];
    logic [ROWS-1:0]  row_lost;
    logic             age_clr;
    logic [AW-1:0]    age_clr_row;
    logic             access_err;

    assign age_clr     = ras_fall && (state == ST_IDLE || state == ST_CBR_PEND);
    assign age_clr_row = (state == ST_CBR_PEND) ? rfsh_row : A;
    assign row_decayed = row_lost[row_q];
    assign access_err  = row_decayed &&
                         ((state == ST_ROW_OPEN && cas_fall && !ras_rise) ||
                          (state == ST_COL_ACTIVE && mem_we));

    // A row that outlives its refresh limit stays lost until a write restores it;
    // opening it afterwards resets the age but cannot bring the data back.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int r = 0; r < ROWS; r++) begin
                age[r] <= '0;
            end
            row_lost    <= '0;
            refresh_err <= 1'b0;
        end else begin
            refresh_err <= access_err;
            for (int r = 0; r < ROWS; r++) begin
                if (age_clr && age_clr_row == AW'(r)) begin
                    age[r] <= '0;
                end else if (age[r] != AGE_MAX) begin
                    age[r] <= age[r] + 1'b1;
                end
                if (mem_we && mem_wa[ADDR_W-1 -: AW] == AW'(r)) begin
                    row_lost[r] <= 1'b0;
                end else if (age[r] == AGE_MAX) begin
                    row_lost[r] <= 1'b1;
                end
            end
        end
    end
`else
    assign row_decayed = 1'b0;
    assign refresh_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_mux_model.sv
// tb/tb_dram_mux_model.sv - randomized bench for dram_mux_model against an associative-array memory model
module tb_dram_mux_model;

    localparam int AW = 7;
    localparam int DW = 4;
`ifdef DRAM_MUX_MODEL_REFRESH_CHECK_EN
    localparam int LIM = 64;
`else
    localparam int LIM = 2048;
`endif

    logic          CLK = 1'b0;
    logic          nRESET;
    logic [AW-1:0] A;
    logic [DW-1:0] Din;
    logic          nWRITE;
    logic          nRAS;
    logic          nCAS;
    logic [DW-1:0] Dout;
    logic          Dout_oe;
    logic [AW-1:0] rfsh_row;
    logic          proto_err;
    logic          refresh_err;

    dram_mux_model #(.AW(AW), .DW(DW), .RFSH_LIMIT(LIM)) dut (
        .CLK(CLK), .nRESET(nRESET), .A(A), .Din(Din), .nWRITE(nWRITE),
        .nRAS(nRAS), .nCAS(nCAS), .Dout(Dout), .Dout_oe(Dout_oe),
        .rfsh_row(rfsh_row), .proto_err(proto_err), .refresh_err(refresh_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [int];
    int            m_rfsh;
    logic [DW-1:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int key(input int row, input int col);
        return (row << AW) | col;
    endfunction

    task automatic open_row(input int row);
        logic [31:0] r;
        r = row;
        A = r[AW-1:0];
        nRAS = 1'b0;
        step();
        A = AW'($urandom);
    endtask

    task automatic close_row();
        nRAS = 1'b1;
        step();
    endtask

    task automatic wr(input int row, input int col, input logic [DW-1:0] d);
        logic [31:0] c;
        c = col;
        A = c[AW-1:0];
        Din = d;
        nWRITE = 1'b0;
        nCAS = 1'b0;
        step();
        chk("wr_oe", 32'(Dout_oe), 0);
        chk("wr_dout_hold", 32'(Dout), 32'(m_dout));
        A = AW'($urandom);
        Din = DW'($urandom);
        nCAS = 1'b1;
        nWRITE = 1'b1;
        step();
        mdl[key(row, col)] = d;
    endtask

    task automatic rd(input int row, input int col, input bit ras_first);
        logic [DW-1:0] exp;
        logic [31:0]   c;
        exp = mdl[key(row, col)];
        c = col;
        A = c[AW-1:0];
        nWRITE = 1'b1;
        nCAS = 1'b0;
        step();
        chk("rd_latency", 32'(Dout_oe), 0);
        A = AW'($urandom);
        step();
        chk("rd_oe", 32'(Dout_oe), 1);
        chk("rd_data", 32'(Dout), 32'(exp));
        m_dout = exp;
        if (ras_first) begin
            nRAS = 1'b1;
            step();
            chk("rd_oe_after_ras", 32'(Dout_oe), 1);
        end
        nCAS = 1'b1;
        step();
        chk("rd_oe_off", 32'(Dout_oe), 0);
        chk("rd_hold", 32'(Dout), 32'(exp));
    endtask

    task automatic rmw(input int row, input int col, input logic [DW-1:0] d);
        logic [DW-1:0] exp;
        logic [31:0]   c;
        exp = mdl[key(row, col)];
        c = col;
        A = c[AW-1:0];
        nWRITE = 1'b1;
        nCAS = 1'b0;
        step();
        step();
        chk("rmw_read", 32'(Dout), 32'(exp));
        Din = d;
        nWRITE = 1'b0;
        step();
        chk("rmw_dout_keep", 32'(Dout), 32'(exp));
        Din = ~d;
        nWRITE = 1'b1;
        step();
        nWRITE = 1'b0;
        step();
        nWRITE = 1'b1;
        nCAS = 1'b1;
        step();
        chk("rmw_oe_off", 32'(Dout_oe), 0);
        mdl[key(row, col)] = d;
        m_dout = exp;
    endtask

    task automatic cbr(input bit cas_rises_first);
        nCAS = 1'b0;
        step();
        Din = DW'($urandom);
        nWRITE = 1'b0;
        nRAS = 1'b0;
        step();
        m_rfsh = (m_rfsh + 1) % (1 << AW);
        if (cas_rises_first) begin
            nCAS = 1'b1;
            step();
            nRAS = 1'b1;
            step();
        end else begin
            nRAS = 1'b1;
            step();
            nCAS = 1'b1;
            step();
        end
        nWRITE = 1'b1;
        step();
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        #2;
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_oe", 32'(Dout_oe), 0);
        chk("rst_rfsh", 32'(rfsh_row), 0);
        chk("rst_proto", 32'(proto_err), 0);
        chk("rst_refresh_err", 32'(refresh_err), 0);
        m_rfsh = 0;
        m_dout = '0;
        step();
        nRESET = 1'b1;
        step();
    endtask

    initial begin
        int start_rfsh;
        bit closed;
        nRESET = 1'b0;
        A = '0;
        Din = '0;
        nWRITE = 1'b1;
        nRAS = 1'b1;
        nCAS = 1'b1;
        step();
        do_reset();

`ifdef DRAM_MUX_MODEL_REFRESH_CHECK_EN
        open_row(3);
        wr(3, 1, 4'h5);
        close_row();
        repeat (100) step();
        open_row(3);
        A = 7'd1;
        nWRITE = 1'b1;
        nCAS = 1'b0;
        step();
        chk("decay_err_pulse", 32'(refresh_err), 1);
        step();
        chk("decay_err_end", 32'(refresh_err), 0);
        chk("decay_dout", 32'(Dout), 0);
        chk("decay_oe", 32'(Dout_oe), 1);
        nCAS = 1'b1;
        step();
        close_row();
        m_dout = '0;

        open_row(4);
        wr(4, 2, 4'h9);
        close_row();
        repeat (48) step();
        open_row(4);
        close_row();
        repeat (48) step();
        open_row(4);
        A = 7'd2;
        nCAS = 1'b0;
        step();
        chk("refreshed_no_err", 32'(refresh_err), 0);
        step();
        chk("refreshed_no_err2", 32'(refresh_err), 0);
        chk("refreshed_data", 32'(Dout), 32'h9);
        nCAS = 1'b1;
        step();
        close_row();
`else
        // Early write then read back in a separate RAS cycle.
        open_row(5);
        wr(5, 9, 4'h1);
        close_row();
        open_row(5);
        rd(5, 9, 1'b0);
        close_row();

        // Page mode writes and reads on one row.
        open_row(8'h12);
        wr(8'h12, 0, 4'hA);
        wr(8'h12, 1, 4'h5);
        wr(8'h12, 2, 4'hF);
        wr(8'h12, 3, 4'h0);
        close_row();
        open_row(8'h12);
        for (int c = 0; c < 4; c++) rd(8'h12, c, c == 3);

        // Read-modify-write on a location holding zero.
        open_row(7);
        wr(7, 3, 4'h0);
        rmw(7, 3, 4'h1);
        close_row();
        open_row(7);
        rd(7, 3, 1'b0);
        close_row();

        // CAS-before-RAS refresh must not touch the array.
        open_row(0);
        wr(0, 0, 4'h6);
        close_row();
        chk("cbr_start", 32'(rfsh_row), 32'(m_rfsh));
        cbr(1'b0);
        chk("cbr_incr", 32'(rfsh_row), 32'(m_rfsh));
        open_row(0);
        rd(0, 0, 1'b0);
        close_row();
        start_rfsh = m_rfsh;
        for (int i = 0; i < (1 << AW); i++) cbr($urandom_range(0, 1) == 1);
        chk("cbr_wrap", 32'(rfsh_row), 32'(start_rfsh));

        // Simultaneous strobe fall: protocol error, row open, no access.
        A = 7'd5;
        Din = 4'hE;
        nWRITE = 1'b0;
        nRAS = 1'b0;
        nCAS = 1'b0;
        step();
        chk("proto_pulse", 32'(proto_err), 1);
        chk("proto_oe", 32'(Dout_oe), 0);
        step();
        chk("proto_end", 32'(proto_err), 0);
        chk("proto_no_read", 32'(Dout_oe), 0);
        nWRITE = 1'b1;
        nCAS = 1'b1;
        step();
        rd(5, 9, 1'b0);
        close_row();

        // Reset in mid-access; strobes stay low across release.
        open_row(8'h12);
        A = 7'd2;
        nWRITE = 1'b1;
        nCAS = 1'b0;
        step();
        step();
        do_reset();
        step();
        chk("post_rst_quiet", 32'(Dout_oe), 0);
        nRAS = 1'b1;
        nCAS = 1'b1;
        step();
        open_row(8'h12);
        rd(8'h12, 2, 1'b0);
        close_row();

        // Randomized page cycles over a small address window.
        for (int i = 0; i < 60; i++) begin
            int row;
            int n;
            row = $urandom_range(0, 7);
            n = $urandom_range(1, 4);
            closed = 1'b0;
            open_row(row);
            for (int j = 0; j < n; j++) begin
                int col;
                int op;
                col = $urandom_range(0, 7);
                op = $urandom_range(0, 2);
                if (!mdl.exists(key(row, col)) || op == 0) begin
                    wr(row, col, DW'($urandom));
                end else if (op == 1) begin
                    closed = (j == n - 1) && ($urandom_range(0, 1) == 1);
                    rd(row, col, closed);
                end else begin
                    rmw(row, col, DW'($urandom));
                end
            end
            if (!closed) close_row();
        end
        chk("rfsh_final", 32'(rfsh_row), 32'(m_rfsh));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
